// File: rtl/video_sync_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : video_sync_pkg                                             |
// | Description : Shared types and default constants for the video sync      |
// |               shaper: hsync FSM state encoding, default timing values    |
// |               and a small width helper.                                  |
// | Options     : SYNC_IRQ_EN (IRQ_LINES is only used when it is defined)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package video_sync_pkg;

   // States of the hsync shaping FSM.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_ACTIVE = 2'd2
   } hs_state_t;

   // Default timing, in character periods (hsync) and lines (vsync).
   localparam int HS_DELAY  = 2;
   localparam int HS_WIDTH  = 4;
   localparam int VS_LINES  = 26;
   // Raster-counter wrap point that raises the interrupt.
   localparam int IRQ_LINES = 52;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_irq_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_irq_counter                                           |
// | Description : 6-bit raster counter that raises an interrupt request      |
// |               every IRQ_LINES lines, and resynchronises to the frame on  |
// |               the second line end after shaped vsync starts.             |
// | Ports       : clk, rst_n      - clock, async active-low reset            |
// |               i_line_end      - one pulse per shaped hsync end           |
// |               i_vs_start      - one pulse when shaped vsync starts       |
// |               i_irq_ack       - one-cycle interrupt acknowledge          |
// |               o_irq           - registered interrupt request             |
// | Options     : only instantiated when SYNC_IRQ_EN is defined              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_irq_counter
   import video_sync_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_line_end,
   input  logic i_vs_start,
   input  logic i_irq_ack,
   output logic o_irq
);

   localparam logic [5:0] C_CNT_LAST = 6'(IRQ_LINES - 1);
   localparam logic [5:0] C_CNT_ONE  = 6'd1;

   logic [5:0] r_cnt;
   logic       r_irq;
   logic       r_track;   // a vsync started and its resync point is pending
   logic       r_seen;    // first line end after vsync start already passed

   logic [5:0] w_cnt_nxt;
   logic       w_set;
   logic       w_track_nxt;
   logic       w_seen_nxt;

   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_set       = 1'b0;
      w_track_nxt = r_track;
      w_seen_nxt  = r_seen;
      if (i_vs_start) begin
         w_track_nxt = 1'b1;
         w_seen_nxt  = 1'b0;
      end
      if (i_line_end) begin
         if (r_track && r_seen) begin
            // Resync point: a count of 32 or more means a raster line was due.
            w_set       = r_cnt[5];
            w_cnt_nxt   = '0;
            w_track_nxt = 1'b0;
            w_seen_nxt  = 1'b0;
         end else begin
            if (r_track) begin
               w_seen_nxt = 1'b1;
            end
            if (r_cnt == C_CNT_LAST) begin
               w_cnt_nxt = '0;
               w_set     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end
      end
      if (i_irq_ack) begin
         w_cnt_nxt[5] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_irq   <= 1'b0;
         r_track <= 1'b0;
         r_seen  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         // A set event wins over a simultaneous acknowledge.
         r_irq   <= w_set | (r_irq & ~i_irq_ack);
         r_track <= w_track_nxt;
         r_seen  <= w_seen_nxt;
      end
   end

   assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/video_sync_shaper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : video_sync_shaper                                          |
// | Description : Reshapes raw CRTC HSYNC/VSYNC into fixed-timing active-low |
// |               syncs for a scandoubler and blanks RGB during syncs.       |
// | Ports       : clkvideo, rst_n           - clock, async active-low reset  |
// |               ce_char                   - character-rate clock enable    |
// |               crtc_hsync, crtc_vsync    - raw CRTC syncs, active high    |
// |               ri, gi, bi                - unblanked colour in            |
// |               ro, go, bo                - blanked colour out (registered)|
// |               hsync/vsync/csync_ext_n   - shaped syncs, active low       |
// |               irq, irq_ack              - raster interrupt (option only) |
// | Options     : SYNC_IRQ_EN - adds the raster interrupt counter and the    |
// |               irq/irq_ack ports                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module video_sync_shaper
   import video_sync_pkg::*;
#(
   parameter int HS_DELAY = video_sync_pkg::HS_DELAY,
   parameter int HS_WIDTH = video_sync_pkg::HS_WIDTH,
   parameter int VS_LINES = video_sync_pkg::VS_LINES
) (
   input  logic       clkvideo,
   input  logic       rst_n,
   input  logic       ce_char,
   input  logic       crtc_hsync,
   input  logic       crtc_vsync,
   input  logic [2:0] ri,
   input  logic [2:0] gi,
   input  logic [2:0] bi,
   output logic [2:0] ro,
   output logic [2:0] go,
   output logic [2:0] bo,
   output logic       hsync_ext_n,
   output logic       vsync_ext_n,
   output logic       csync_ext_n
`ifdef SYNC_IRQ_EN
   ,
   output logic       irq,
   input  logic       irq_ack
`endif
);

   localparam int C_HCNT_W = $clog2(max_int(HS_DELAY, HS_WIDTH) + 1);
   localparam int C_VCNT_W = $clog2(VS_LINES + 1);

   localparam logic [C_HCNT_W-1:0] C_DELAY_LAST = C_HCNT_W'(HS_DELAY - 1);
   localparam logic [C_HCNT_W-1:0] C_WIDTH_LAST = C_HCNT_W'(HS_WIDTH - 1);
   localparam logic [C_HCNT_W-1:0] C_HCNT_ONE   = C_HCNT_W'(1);
   localparam logic [C_VCNT_W-1:0] C_VS_LAST    = C_VCNT_W'(VS_LINES - 1);
   localparam logic [C_VCNT_W-1:0] C_VCNT_ONE   = C_VCNT_W'(1);

   hs_state_t             r_state;
   logic [C_HCNT_W-1:0]   r_hcnt;
   logic                  r_hs_prev;
   logic                  r_vs_prev;
   logic                  r_vs_armed;
   logic                  r_vs_active;
   logic [C_VCNT_W-1:0]   r_vcnt;

   logic w_hs_rise;
   logic w_hs_fall;
   logic w_vs_rise;
   logic w_hs_active;
   logic w_to_active;
   logic w_to_idle;

   always_comb begin
      w_hs_rise   = crtc_hsync & ~r_hs_prev;
      w_hs_fall   = ~crtc_hsync & r_hs_prev;
      w_vs_rise   = crtc_vsync & ~r_vs_prev;
      w_hs_active = (r_state == ST_ACTIVE);
      // A fall during DELAY takes priority over the terminal count.
      w_to_active = (r_state == ST_DELAY) && !w_hs_fall && ce_char &&
                    (r_hcnt == C_DELAY_LAST);
      w_to_idle   = (r_state == ST_ACTIVE) &&
                    (w_hs_fall || (ce_char && (r_hcnt == C_WIDTH_LAST)));
   end

   // Previous-cycle samples reset high so that a sync already high when
   // reset releases is not mistaken for a fresh rising edge.
   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_prev <= 1'b1;
         r_vs_prev <= 1'b1;
      end else begin
         r_hs_prev <= crtc_hsync;
         r_vs_prev <= crtc_vsync;
      end
   end

   // Hsync shaping FSM with its character counter.
   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hcnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs_rise) begin
                  r_state <= ST_DELAY;
                  r_hcnt  <= '0;
               end
            end
            ST_DELAY: begin
               if (w_hs_fall) begin
                  r_state <= ST_IDLE;
                  r_hcnt  <= '0;
               end else if (w_to_active) begin
                  r_state <= ST_ACTIVE;
                  r_hcnt  <= '0;
               end else if (ce_char) begin
                  r_hcnt  <= r_hcnt + C_HCNT_ONE;
               end
            end
            ST_ACTIVE: begin
               if (w_to_idle) begin
                  r_state <= ST_IDLE;
                  r_hcnt  <= '0;
               end else if (ce_char) begin
                  r_hcnt  <= r_hcnt + C_HCNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hcnt  <= '0;
            end
         endcase
      end
   end

   // Vsync: armed by a CRTC vsync rise, started at the next hsync start and
   // held for VS_LINES shaped hsync ends. The CRTC vsync fall is ignored.
   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_armed  <= 1'b0;
         r_vs_active <= 1'b0;
         r_vcnt      <= '0;
      end else begin
         if (w_vs_rise && !r_vs_active) begin
            r_vs_armed <= 1'b1;
         end
         if (w_to_active && r_vs_armed) begin
            r_vs_armed  <= 1'b0;
            r_vs_active <= 1'b1;
            r_vcnt      <= '0;
         end else if (w_to_idle && r_vs_active) begin
            if (r_vcnt == C_VS_LAST) begin
               r_vs_active <= 1'b0;
               r_vcnt      <= '0;
            end else begin
               r_vcnt      <= r_vcnt + C_VCNT_ONE;
            end
         end
      end
   end

   // Registered outputs: syncs and blanked colour share one cycle of latency.
   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         hsync_ext_n <= 1'b1;
         vsync_ext_n <= 1'b1;
         csync_ext_n <= 1'b1;
         ro          <= '0;
         go          <= '0;
         bo          <= '0;
      end else begin
         hsync_ext_n <= ~w_hs_active;
         vsync_ext_n <= ~r_vs_active;
         csync_ext_n <= ~(w_hs_active ^ r_vs_active);
         if (w_hs_active || r_vs_active) begin
            ro <= '0;
            go <= '0;
            bo <= '0;
         end else begin
            ro <= ri;
            go <= gi;
            bo <= bi;
         end
      end
   end

`ifdef SYNC_IRQ_EN
   logic w_vs_start;

   assign w_vs_start = w_to_active & r_vs_armed;

   sync_irq_counter u_irq (
      .clk        (clkvideo),
      .rst_n      (rst_n),
      .i_line_end (w_to_idle),
      .i_vs_start (w_vs_start),
      .i_irq_ack  (irq_ack),
      .o_irq      (irq)
   );
`endif

endmodule
`default_nettype wire
